// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon rate-block packer.
package ascon_pkg;

  localparam int IN_W_DEF   = 64;
  localparam int RATE_W_DEF = 128;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    PADBLK = 1'b1
  } packer_state_t;

endpackage

// File: rtl/ascon_pad_word.sv
// Combinational pad stage: on the last word, keeps bytes below nbytes_i,
// places the pad byte at position nbytes_i and zeroes the bytes above it.
// Non-last words pass through untouched.
module ascon_pad_word
  import ascon_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic [IN_W-1:0]           word_i,
  input  logic [$clog2(IN_W/8):0]   nbytes_i,
  input  logic                      last_i,
  output logic [IN_W-1:0]           word_o
);

  localparam int BPW = IN_W / 8;

  // Byte-wise mask and pad insertion; byte 0 is the most significant byte.
  always_comb begin
    word_o = word_i;
    if (last_i) begin
      for (int b = 0; b < BPW; b++) begin
        if (b == int'(nbytes_i)) begin
          word_o[IN_W-1-8*b -: 8] = PAD_BYTE;
        end else if (b > int'(nbytes_i)) begin
          word_o[IN_W-1-8*b -: 8] = 8'h00;
        end
      end
    end
  end

endmodule

// File: rtl/ascon_rate_packer.sv
// Packs IN_W-bit message words into padded RATE_W-bit Ascon rate blocks and
// hands them out over a valid/ready interface. Input is stalled while a block
// is waiting, which costs one bubble per block.
module ascon_rate_packer
  import ascon_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  input  logic [$clog2(IN_W/8):0]     in_bytes,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RATE_W-1:0]           out_block,
  output logic [$clog2(RATE_W/8):0]   out_nbytes,
  output logic                        out_last
);

  localparam int WORDS = RATE_W / IN_W;
  localparam int BPW   = IN_W / 8;
  localparam int LW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IBW   = $clog2(IN_W/8) + 1;
  localparam int OBW   = $clog2(RATE_W/8) + 1;

  packer_state_t      state_q, state_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic               out_valid_q, out_valid_d;
  logic [RATE_W-1:0]  out_block_q, out_block_d;
  logic [OBW-1:0]     out_nbytes_q, out_nbytes_d;
  logic               out_last_q, out_last_d;

  logic [IBW-1:0]     n_c;
  logic [IN_W-1:0]    padded_c;
  logic               accept_c;
  logic               lane_last_c;
  logic               full_last_c;

  // Byte count of the final word is clamped to a whole word.
  assign n_c         = (in_bytes > IBW'(BPW)) ? IBW'(BPW) : in_bytes;
  assign in_ready    = (state_q == FILL) && !out_valid_q;
  assign accept_c    = in_valid && in_ready;
  assign lane_last_c = (lane_q == LW'(WORDS-1));
  assign full_last_c = in_last && (n_c == IBW'(BPW));

  ascon_pad_word #(.IN_W(IN_W)) u_pad (
    .word_i   (in_data),
    .nbytes_i (n_c),
    .last_i   (in_last),
    .word_o   (padded_c)
  );

  // State, lane counter and output block registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      lane_q       <= '0;
      out_valid_q  <= 1'b0;
      out_block_q  <= '0;
      out_nbytes_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      out_valid_q  <= out_valid_d;
      out_block_q  <= out_block_d;
      out_nbytes_q <= out_nbytes_d;
      out_last_q   <= out_last_d;
    end
  end

  // Next-state: lane fill, block completion, padding and the extra pad block.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    out_valid_d  = out_valid_q;
    out_block_d  = out_block_q;
    out_nbytes_d = out_nbytes_q;
    out_last_d   = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == PADBLK) begin
      // Full final block already handed over; emit the standalone pad block.
      if (!out_valid_q) begin
        out_block_d  = {PAD_BYTE, {(RATE_W-8){1'b0}}};
        out_nbytes_d = '0;
        out_last_d   = 1'b1;
        out_valid_d  = 1'b1;
        state_d      = FILL;
      end
    end else if (accept_c) begin
      for (int i = 0; i < WORDS; i++) begin
        if (i == int'(lane_q)) begin
          out_block_d[RATE_W-1-i*IN_W -: IN_W] = padded_c;
        end else if (in_last && (i > int'(lane_q))) begin
          if (full_last_c && (i == int'(lane_q) + 1)) begin
            out_block_d[RATE_W-1-i*IN_W -: IN_W] = {PAD_BYTE, {(IN_W-8){1'b0}}};
          end else begin
            out_block_d[RATE_W-1-i*IN_W -: IN_W] = '0;
          end
        end
      end

      if (in_last) begin
        out_valid_d  = 1'b1;
        out_nbytes_d = OBW'(int'(lane_q) * BPW + int'(n_c));
        lane_d       = '0;
        if (full_last_c && lane_last_c) begin
          out_last_d = 1'b0;
          state_d    = PADBLK;
        end else begin
          out_last_d = 1'b1;
        end
      end else if (lane_last_c) begin
        out_valid_d  = 1'b1;
        out_nbytes_d = OBW'(RATE_W/8);
        out_last_d   = 1'b0;
        lane_d       = '0;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_block  = out_block_q;
  assign out_nbytes = out_nbytes_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_ascon_rate_packer.sv
// Directed bench for ascon_rate_packer with IN_W=64, RATE_W=128.
module tb_ascon_rate_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [3:0]   in_bytes;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic [4:0]   out_nbytes;
  logic         out_last;

  int n_cmp = 0;
  int n_bad = 0;

  ascon_rate_packer #(.IN_W(64), .RATE_W(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_bytes   (in_bytes),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .out_nbytes (out_nbytes),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input string tag, input logic [63:0] d, input logic [3:0] nb, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = nb;
    in_last  = l;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_accept"}, 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for a block (bounded), compare all fields, let the handshake happen.
  task automatic expect_blk(input string tag, input logic [127:0] eb, input logic [4:0] en,
                            input logic el, input int ewait);
    int t;
    t = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"},  128'(out_valid),  128'(1));
    chk({tag, "_block"},  out_block,        eb);
    chk({tag, "_nbytes"}, 128'(out_nbytes), 128'(en));
    chk({tag, "_last"},   128'(out_last),   128'(el));
    chk({tag, "_inrdy"},  128'(in_ready),   128'(0));
    if (ewait >= 0) chk({tag, "_latency"}, 128'(t), 128'(ewait));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_bytes  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  128'(out_valid),  128'(0));
    chk("rst_block",  out_block,        128'(0));
    chk("rst_nbytes", 128'(out_nbytes), 128'(0));
    chk("rst_last",   128'(out_last),   128'(0));
    chk("rst_inrdy",  128'(in_ready),   128'(1));
    @(negedge clk);
    reset = 1'b0;

    // Full two-word message: full block, then a standalone pad block.
    send("t1_w0", 64'h0011223344556677, 4'd8, 1'b0);
    send("t1_w1", 64'h8899AABBCCDDEEFF, 4'd8, 1'b1);
    expect_blk("t1_blk", 128'h00112233445566778899AABBCCDDEEFF, 5'd16, 1'b0, 0);
    expect_blk("t1_pad", 128'h80000000000000000000000000000000, 5'd0, 1'b1, -1);

    // Three-byte message.
    send("t2_w0", 64'hAABBCCDDEEFF0011, 4'd3, 1'b1);
    expect_blk("t2_blk", 128'hAABBCC80000000000000000000000000, 5'd3, 1'b1, 0);

    // One full word: pad lands at the start of lane 1.
    send("t3_w0", 64'h0102030405060708, 4'd8, 1'b1);
    expect_blk("t3_blk", 128'h01020304050607088000000000000000, 5'd8, 1'b1, 0);

    // Empty message: data bits must all be masked.
    send("t4_w0", 64'hFFFFFFFFFFFFFFFF, 4'd0, 1'b1);
    expect_blk("t4_blk", 128'h80000000000000000000000000000000, 5'd0, 1'b1, 0);

    // Oversized byte count clamps to a full word.
    send("t4b_w0", 64'h0102030405060708, 4'd15, 1'b1);
    expect_blk("t4b_blk", 128'h01020304050607088000000000000000, 5'd8, 1'b1, 0);

    // Empty last word on lane 1.
    send("t4c_w0", 64'h1122334455667788, 4'd8, 1'b0);
    send("t4c_w1", 64'hFFFFFFFFFFFFFFFF, 4'd0, 1'b1);
    expect_blk("t4c_blk", 128'h11223344556677888000000000000000, 5'd8, 1'b1, 0);

    // Back-pressure: block held for 5 cycles while the next word waits.
    out_ready = 1'b0;
    send("t5_w0", 64'hDEADBEEF01234567, 4'd0, 1'b0);
    send("t5_w1", 64'h76543210FEEDFACE, 4'd8, 1'b0);
    in_valid = 1'b1;
    in_data  = 64'hA1A2A3A4A5A6A7A8;
    in_bytes = 4'd8;
    in_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_hold_valid",  128'(out_valid),  128'(1));
      chk("t5_hold_block",  out_block,        128'hDEADBEEF0123456776543210FEEDFACE);
      chk("t5_hold_nbytes", 128'(out_nbytes), 128'(16));
      chk("t5_hold_inrdy",  128'(in_ready),   128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_rel_valid", 128'(out_valid), 128'(0));
    chk("t5_rel_inrdy", 128'(in_ready),  128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send("t5_w3", 64'hB1B2B3B4B5B6B7B8, 4'd2, 1'b1);
    expect_blk("t5_blk", 128'hA1A2A3A4A5A6A7A8B1B2800000000000, 5'd10, 1'b1, 0);

    // Reset in the middle of a block discards the partial lane.
    send("t6_w0", 64'h123456789ABCDEF0, 4'd8, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 128'(out_valid), 128'(0));
    chk("t6_rst_block", out_block,       128'(0));
    chk("t6_rst_inrdy", 128'(in_ready),  128'(1));
    @(negedge clk);
    reset = 1'b0;
    send("t6_w1", 64'hCAFEBABE00000000, 4'd4, 1'b1);
    expect_blk("t6_blk", 128'hCAFEBABE800000000000000000000000, 5'd4, 1'b1, 0);

    @(negedge clk);
    chk("end_idle_valid", 128'(out_valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
